// File: rtl/myproject_dot_accum.sv
// Streaming dot-product accumulator: sums N_TERMS signed products, requantizes
// with round-half-up and an arithmetic right shift, then saturates to OUT_WIDTH.
module myproject_dot_accum #(
  parameter int PROD_WIDTH = 25,
  parameter int N_TERMS    = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int SHIFT      = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  clear,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  out_valid,
  input  logic                  out_ready
);

  if (N_TERMS < 2) begin : g_bad_terms
    $error("myproject_dot_accum: N_TERMS must be at least 2");
  end
  if (ACC_WIDTH < PROD_WIDTH + $clog2(N_TERMS)) begin : g_bad_acc
    $error("myproject_dot_accum: ACC_WIDTH too small for PROD_WIDTH + clog2(N_TERMS)");
  end
  if (SHIFT < 1) begin : g_bad_shift
    $error("myproject_dot_accum: SHIFT must be at least 1");
  end
  if (ACC_WIDTH < OUT_WIDTH) begin : g_bad_out
    $error("myproject_dot_accum: ACC_WIDTH must be at least OUT_WIDTH");
  end

  localparam int CNT_W = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

  // Rounding constant and clamp limits, all at ACC_WIDTH+1 bits.
  localparam logic signed [ACC_WIDTH:0] RND_C =
    $signed({{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1));
  localparam logic signed [ACC_WIDTH:0] MAX_C =
    $signed({{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}});
  localparam logic signed [ACC_WIDTH:0] MIN_C =
    $signed({{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}});

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] sum
  );
    logic signed [ACC_WIDTH:0] wide;
    wide = $signed({sum[ACC_WIDTH-1], sum});
    return (wide + RND_C) >>> SHIFT;
  endfunction

  // Returns {clamped_flag, clamped_value}.
  function automatic logic [OUT_WIDTH:0] saturate(
    input logic signed [ACC_WIDTH:0] r
  );
    logic [OUT_WIDTH:0] res;
    if (r > MAX_C) begin
      res = {1'b1, MAX_C[OUT_WIDTH-1:0]};
    end else if (r < MIN_C) begin
      res = {1'b1, MIN_C[OUT_WIDTH-1:0]};
    end else begin
      res = {1'b0, r[OUT_WIDTH-1:0]};
    end
    return res;
  endfunction

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;
  logic                         out_valid_q, out_valid_d;

  logic signed [ACC_WIDTH-1:0]  prod_ext_s;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic signed [ACC_WIDTH:0]    round_s;
  logic [OUT_WIDTH:0]           sat_s;
  logic                         accept_s;
  logic                         release_s;
  logic                         last_s;

  assign prod_ext_s = $signed({{(ACC_WIDTH - PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod});
  assign sum_s      = acc_q + prod_ext_s;
  assign round_s    = round_shift(sum_s);
  assign sat_s      = saturate(round_s);

  // Ready depends on out_ready only while a result is held; never on in_valid.
  assign in_ready  = ap_rst_n & ((state_q == ST_ACCUM) | out_ready);
  assign accept_s  = in_valid & in_ready;
  assign release_s = out_valid_q & out_ready;
  assign last_s    = (cnt_q == LAST_C);

  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

  // Next-state logic: accumulation, final requantize, hold/release, clear.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      state_d     = ST_ACCUM;
      acc_d       = '0;
      cnt_d       = ZERO_C;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_s) begin
            if (last_s) begin
              out_data_d  = sat_s[OUT_WIDTH-1:0];
              out_sat_d   = sat_s[OUT_WIDTH];
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = ZERO_C;
              state_d     = ST_HOLD;
            end else begin
              acc_d = sum_s;
              cnt_d = cnt_q + ONE_C;
            end
          end else begin
            acc_d = acc_q;
          end
        end
        ST_HOLD: begin
          if (release_s) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACCUM;
            // A product taken during release starts the next vector.
            if (accept_s) begin
              acc_d = prod_ext_s;
              cnt_d = ONE_C;
            end else begin
              acc_d = acc_q;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d     = ST_ACCUM;
          acc_d       = '0;
          cnt_d       = ZERO_C;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= ZERO_C;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_myproject_dot_accum.sv
// Scoreboard bench for myproject_dot_accum: stimulus pushes expected results,
// a negedge monitor pops and compares on every release.
module tb_myproject_dot_accum;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        clear;
  logic [24:0] in_prod;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [16:0] sb[$];

  myproject_dot_accum dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .clear     (clear),
    .in_prod   (in_prod),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a release happens at the next posedge when valid&ready at negedge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(out_data), 32'hDEAD);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e[15:0]));
        chk("out_sat", 32'(out_sat), 32'(e[16]));
      end
    end
  end

  task automatic send_one(input int p);
    bit done = 1'b0;
    int waited = 0;
    in_valid = 1'b1;
    in_prod  = p[24:0];
    while (!done && waited < 50) begin
      @(negedge ap_clk);
      if (in_ready) done = 1'b1;
      @(posedge ap_clk);
      #1;
      waited++;
    end
    chk("accept", 32'(done), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int first, input int rest,
                          input logic [15:0] exp_d, input logic exp_s);
    sb.push_back({exp_s, exp_d});
    send_one(first);
    for (int i = 1; i < 16; i++) send_one(rest);
    chk("latency_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    int c1, c2, w;
    ap_rst_n  = 1'b0;
    clear     = 1'b0;
    in_prod   = '0;
    in_valid  = 1'b1;
    out_ready = 1'b1;

    @(negedge ap_clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    ap_rst_n = 1'b1;
    idle(2);

    // Basic vector and back-to-back throughput.
    send_vec(256, 256, 16'd16, 1'b0);
    c1 = cyc;
    send_vec(256, 256, 16'd16, 1'b0);
    c2 = cyc;
    chk("b2b_spacing", 32'(c2 - c1), 32'd16);
    idle(3);

    // Rounding.
    send_vec(384, 0, 16'd2, 1'b0);
    send_vec(-384, 0, 16'hFFFF, 1'b0);
    send_vec(127, 0, 16'd0, 1'b0);
    send_vec(128, 0, 16'd1, 1'b0);
    idle(3);

    // Saturation.
    send_vec(8388608, 8388608, 16'h7FFF, 1'b1);
    send_vec(-8355840, -8355840, 16'h8000, 1'b1);
    idle(3);

    // Backpressure while holding a result.
    out_ready = 1'b0;
    send_vec(256, 256, 16'd16, 1'b0);
    in_valid = 1'b1;
    in_prod  = 25'd999;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'd16);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge ap_clk); #1;
    out_ready = 1'b1;
    send_vec(512, 512, 16'd32, 1'b0);
    idle(3);

    // clear mid-vector discards partial sum and the product offered that cycle.
    for (int i = 0; i < 7; i++) send_one(1000);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 25'd9999;
    @(posedge ap_clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    send_vec(256, 256, 16'd16, 1'b0);
    idle(3);

    // Reset mid-vector.
    for (int i = 0; i < 9; i++) send_one(1000);
    in_valid = 1'b1;
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("rstmid_in_ready", 32'(in_ready), 32'd0);
    chk("rstmid_out_data", 32'(out_data), 32'd0);
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    ap_rst_n = 1'b1;
    send_vec(256, 256, 16'd16, 1'b0);
    idle(3);

    // Reset while holding a saturated result.
    out_ready = 1'b0;
    send_vec(8388608, 8388608, 16'h7FFF, 1'b1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("rsthold_out_valid", 32'(out_valid), 32'd0);
    chk("rsthold_out_data", 32'(out_data), 32'd0);
    chk("rsthold_out_sat", 32'(out_sat), 32'd0);
    void'(sb.pop_back());
    @(posedge ap_clk); #1;
    ap_rst_n  = 1'b1;
    out_ready = 1'b1;
    send_vec(256, 256, 16'd16, 1'b0);

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(posedge ap_clk);
      w++;
    end
    #1;
    chk("drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/myproject_dot_accum.md
# myproject_dot_accum

Streaming dot-product accumulator that consumes the signed 25-bit products from the 16s×9s multiplier stage, which multiplies 16-bit activations by 9-bit weights. It sums a fixed number of products per output element, then requantizes the sum with round-half-up and a right shift. The result is saturated to a 16-bit signed value, which feeds the next layer of the hashed-attention datapath. Input and output use valid/ready handshakes, so the stage absorbs downstream backpressure without losing products.

## Interface
Parameters:
- PROD_WIDTH, 25: width of the signed product input.
- N_TERMS, 16: number of products summed per output; must be at least 2.
- ACC_WIDTH, 32: accumulator width. Elaboration error if ACC_WIDTH < PROD_WIDTH + clog2(N_TERMS).
- SHIFT, 8: requantization right-shift; must be at least 1.
- OUT_WIDTH, 16: width of the signed output.

Ports (one clock; reset is asynchronous and active-low):
- ap_clk, in, 1: clock; all state updates on the rising edge.
- ap_rst_n, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous flush of the partial sum and any held output.
- in_prod, in, PROD_WIDTH: signed product from the multiplier.
- in_valid, in, 1: in_prod is valid.
- in_ready, out, 1: stage accepts in_prod this cycle.
- out_data, out, OUT_WIDTH: signed requantized sum.
- out_sat, out, 1: out_data was clamped; qualified by out_valid.
- out_valid, out, 1: out_data/out_sat valid.
- out_ready, in, 1: consumer accepts the output.

## Operation
States:
- ACCUM: collecting products.
- HOLD: a result is registered and waiting for the consumer.

Reset behaviour:
- ap_rst_n low clears everything: state=ACCUM, acc=0, cnt=0, out_data=0, out_sat=0, out_valid=0.
- in_ready is 0 while ap_rst_n is low.

in_ready:
- 1 in ACCUM.
- In HOLD, in_ready = out_ready.

Accept and release conditions:
- An accept is a cycle with in_valid && in_ready.
- A release is a cycle with out_valid && out_ready.

Accumulation:
- On each accept, in_prod is sign-extended to ACC_WIDTH and added to acc, and cnt increments.
- cnt runs 0..N_TERMS-1. By construction the sum cannot overflow.

Final accept (cnt == N_TERMS-1):
- s = acc + in_prod.
- r = (s + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, computed at ACC_WIDTH+1 bits.
- r is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- out_data ← clamped r; out_sat ← (r was clamped); out_valid ← 1; acc ← 0; cnt ← 0; state ← HOLD.

HOLD:
- out_data and out_sat stay stable until release.
- On release: out_valid ← 0 and state ← ACCUM.
- If the same cycle also accepts a product, that product becomes term 0 of the next vector: acc ← in_prod, cnt ← 1.

Boundary cases:
- Release and final accept in the same cycle: only possible when N_TERMS=1, which is disallowed by the parameter rule.
- clear has priority over everything. It sets acc=0, cnt=0, out_valid=0, state=ACCUM. An in_prod presented that cycle is discarded; in_ready is still driven per state, so the bench must not count that transfer.
- in_valid low mid-vector: acc and cnt hold; no timeout.

## Timing
- out_valid rises on the clock edge that registers the final accept, with out_data valid in the same cycle. Latency from the final in_prod to out_data is 1 cycle.
- Throughput: one output per N_TERMS cycles with zero bubbles when out_ready is held high.
- in_ready combinationally depends on out_ready in HOLD only. There is no combinational path from in_valid to in_ready.

## Test plan
- Sixteen products of 256, out_ready=1 → 1 cycle after the 16th: out_data=16, out_sat=0. A second identical vector back-to-back gives 16 again, exactly 16 cycles later.
- Rounding: 384 then fifteen 0s → 2. -384 then fifteen 0s → -1. 127 then fifteen 0s → 0. 128 then fifteen 0s → 1.
- Saturation: sixteen of 8388608 → 32767, out_sat=1. Sixteen of -8355840 → -32768, out_sat=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_data stable and in_ready=0. Then out_ready=1 with in_valid=1 and in_prod=512 → 512 is taken as the first term, and the next vector of 512s gives 32.
- clear after 7 accepted products, then 16 products of 256 → 16, with no contribution from the flushed terms.
- ap_rst_n pulsed low mid-vector (after 9 terms) and during HOLD → all outputs 0 immediately. A following full vector gives the correct result.
